// File: rtl/bist_tpg_ctrl.sv
// bist_tpg_ctrl
//   BIST pattern generator and controller placed in front of a 3-bit
//   NOR-based MISR. It runs a 3-bit maximal-length LFSR into the CUT and
//   routes the CUT response onto the MISR e inputs. The MISR has no reset,
//   so the controller holds e=111 outside RUN, which parks the MISR at 000.
//   After N_PATTERNS patterns it compares the MISR signature against
//   GOLDEN_SIG and reports done/pass.
//
// Ports
//   CLK       in   1  clock, rising edge
//   RST_N     in   1  asynchronous active-low reset
//   start     in   1  run request, honoured in IDLE or DONE only
//   tpg_pat   out  3  registered LFSR pattern to the CUT
//   cut_resp  in   3  CUT response (combinational from tpg_pat)
//   misr_e    out  3  {e2,e1,e0} to the MISR
//   misr_h    in   3  {h2,h1,h0} from the MISR
//   busy      out  1  high in INIT, RUN, CHECK
//   done      out  1  registered, high in DONE
//   pass      out  1  registered compare result, valid while done=1
module bist_tpg_ctrl #(
    parameter int unsigned N_PATTERNS = 7,
    parameter logic [2:0]  LFSR_SEED  = 3'b001,
    parameter logic [2:0]  GOLDEN_SIG = 3'b110
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       start,
    output logic [2:0] tpg_pat,
    input  logic [2:0] cut_resp,
    output logic [2:0] misr_e,
    input  logic [2:0] misr_h,
    output logic       busy,
    output logic       done,
    output logic       pass
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_RUN   = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [7:0] LP_LAST = 8'(N_PATTERNS - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_lfsr;
    logic [7:0] r_cnt;
    logic       r_done;
    logic       r_pass;

    logic       w_load_seed;
    logic       w_advance;
    logic       w_clr_cnt;
    logic       w_capture;
    logic       w_clr_result;

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, datapath controls and MISR input mux
    always_comb begin
        w_state_nxt  = r_state;
        w_load_seed  = 1'b0;
        w_advance    = 1'b0;
        w_clr_cnt    = 1'b0;
        w_capture    = 1'b0;
        w_clr_result = 1'b0;
        misr_e       = 3'b111;
        busy         = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_INIT;
                    w_load_seed = 1'b1;
                end
            end
            S_INIT: begin
                busy        = 1'b1;
                w_clr_cnt   = 1'b1;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                busy      = 1'b1;
                misr_e    = cut_resp;
                w_advance = 1'b1;
                if (r_cnt == LP_LAST) begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                // The MISR clears on the same edge; misr_h still shows the
                // final signature before that edge.
                busy        = 1'b1;
                w_capture   = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (start) begin
                    w_state_nxt  = S_INIT;
                    w_load_seed  = 1'b1;
                    w_clr_result = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // LFSR, pattern counter and result flags
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_lfsr <= LFSR_SEED;
            r_cnt  <= '0;
            r_done <= 1'b0;
            r_pass <= 1'b0;
        end else begin
            if (w_load_seed) begin
                r_lfsr <= LFSR_SEED;
            end else if (w_advance) begin
                r_lfsr <= {r_lfsr[1:0], r_lfsr[2] ^ r_lfsr[1]};
            end

            if (w_clr_cnt) begin
                r_cnt <= '0;
            end else if (w_advance) begin
                r_cnt <= r_cnt + 8'd1;
            end

            if (w_capture) begin
                r_done <= 1'b1;
                r_pass <= (misr_h == GOLDEN_SIG);
            end else if (w_clr_result) begin
                r_done <= 1'b0;
                r_pass <= 1'b0;
            end
        end
    end

    assign tpg_pat = r_lfsr;
    assign done    = r_done;
    assign pass    = r_pass;

endmodule

// File: tb/tb_bist_tpg_ctrl.sv
// tb_bist_tpg_ctrl
//   Directed bench for bist_tpg_ctrl. Two instances: N=7/GOLDEN=110 and
//   N=3/GOLDEN=010. The CUT is the identity function with an optional
//   stuck-at-0 mask; the MISR is a stub whose h outputs the bench sets to
//   the signature the real MISR would show for that run.
module tb_bist_tpg_ctrl;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       start;
    logic       sel;
    logic [2:0] stuck_mask;
    logic [2:0] misr_h;

    logic [2:0] tpg_a, tpg_b, e_a, e_b, resp_a, resp_b;
    logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic       start_a, start_b;

    logic [2:0] tpg_s, e_s;
    logic       busy_s, done_s, pass_s;

    int n_chk = 0;
    int n_bad = 0;

    // LFSR sequence from seed 001
    logic [2:0] pat [0:6] = '{3'b001, 3'b010, 3'b101, 3'b011,
                              3'b111, 3'b110, 3'b100};

    always #5 CLK = ~CLK;

    assign start_a = start & ~sel;
    assign start_b = start &  sel;
    assign resp_a  = tpg_a & stuck_mask;
    assign resp_b  = tpg_b & stuck_mask;

    assign tpg_s  = sel ? tpg_b  : tpg_a;
    assign e_s    = sel ? e_b    : e_a;
    assign busy_s = sel ? busy_b : busy_a;
    assign done_s = sel ? done_b : done_a;
    assign pass_s = sel ? pass_b : pass_a;

    bist_tpg_ctrl #(
        .N_PATTERNS (7),
        .LFSR_SEED  (3'b001),
        .GOLDEN_SIG (3'b110)
    ) u_dut_a (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .start    (start_a),
        .tpg_pat  (tpg_a),
        .cut_resp (resp_a),
        .misr_e   (e_a),
        .misr_h   (misr_h),
        .busy     (busy_a),
        .done     (done_a),
        .pass     (pass_a)
    );

    bist_tpg_ctrl #(
        .N_PATTERNS (3),
        .LFSR_SEED  (3'b001),
        .GOLDEN_SIG (3'b010)
    ) u_dut_b (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .start    (start_b),
        .tpg_pat  (tpg_b),
        .cut_resp (resp_b),
        .misr_e   (e_b),
        .misr_h   (misr_h),
        .busy     (busy_b),
        .done     (done_b),
        .pass     (pass_b)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One run from IDLE/DONE. Inputs change and outputs are sampled on the
    // falling edge. pulse_k >= 0 raises start for one cycle during RUN k.
    task automatic run(input int n, input logic [2:0] mask, input logic [2:0] sig,
                       input logic exp_pass, input int pulse_k);
        stuck_mask = mask;
        misr_h     = sig;
        @(negedge CLK); start = 1'b1;
        @(negedge CLK); start = 1'b0;            // INIT (after E0)
        check("init_busy", 8'(busy_s), 8'd1);
        check("init_e",    8'(e_s),    8'h7);
        check("init_done", 8'(done_s), 8'd0);
        check("init_pass", 8'(pass_s), 8'd0);
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);                      // RUN k
            start = 1'b0;
            check("run_pat",  8'(tpg_s),  8'(pat[k]));
            check("run_e",    8'(e_s),    8'(pat[k] & mask));
            check("run_busy", 8'(busy_s), 8'd1);
            check("run_done", 8'(done_s), 8'd0);
            if (k == pulse_k) start = 1'b1;
        end
        @(negedge CLK); start = 1'b0;            // CHECK
        check("chk_busy", 8'(busy_s), 8'd1);
        check("chk_e",    8'(e_s),    8'h7);
        check("chk_done", 8'(done_s), 8'd0);
        @(negedge CLK);                          // DONE, edge E(N+2)
        check("done_done", 8'(done_s), 8'd1);
        check("done_pass", 8'(pass_s), 8'(exp_pass));
        check("done_busy", 8'(busy_s), 8'd0);
        check("done_e",    8'(e_s),    8'h7);
        check("done_pat",  8'(tpg_s),  8'(pat[n % 7]));
        @(negedge CLK);                          // DONE holds
        check("hold_done", 8'(done_s), 8'd1);
        check("hold_pass", 8'(pass_s), 8'(exp_pass));
        check("hold_pat",  8'(tpg_s),  8'(pat[n % 7]));
    endtask

    initial begin
        RST_N      = 1'b0;
        start      = 1'b0;
        sel        = 1'b0;
        stuck_mask = 3'b111;
        misr_h     = 3'b000;

        // Reset held with start toggling
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK); start = ~start;
        end
        @(negedge CLK);
        start = 1'b0;
        check("rst_pat",  8'(tpg_a),  8'h1);
        check("rst_e",    8'(e_a),    8'h7);
        check("rst_busy", 8'(busy_a), 8'd0);
        check("rst_done", 8'(done_a), 8'd0);
        check("rst_pass", 8'(pass_a), 8'd0);
        RST_N = 1'b1;

        // Identity CUT, N=7, signature 110
        run(7, 3'b111, 3'b110, 1'b1, -1);
        // cut_resp[1] stuck at 0, signature 010
        run(7, 3'b101, 3'b010, 1'b0, -1);
        // start during RUN ignored, then identical rerun from DONE
        run(7, 3'b111, 3'b110, 1'b1, 2);
        run(7, 3'b111, 3'b110, 1'b1, -1);

        // N=3 instance, signature 010
        sel = 1'b1;
        run(3, 3'b111, 3'b010, 1'b1, -1);
        sel = 1'b0;

        // Reset pulse in RUN cycle 3
        stuck_mask = 3'b111;
        misr_h     = 3'b110;
        @(negedge CLK); start = 1'b1;
        @(negedge CLK); start = 1'b0;
        repeat (4) @(negedge CLK);
        check("mid_pat", 8'(tpg_a), 8'(pat[3]));
        #2 RST_N = 1'b0;
        #1;
        check("arst_pat",  8'(tpg_a),  8'h1);
        check("arst_e",    8'(e_a),    8'h7);
        check("arst_busy", 8'(busy_a), 8'd0);
        check("arst_done", 8'(done_a), 8'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            check("arst_nodone", 8'(done_a), 8'd0);
        end
        RST_N = 1'b1;
        run(7, 3'b111, 3'b110, 1'b1, -1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
